mc_clk_phase_tracker: RTL
=========================

MC_CLK_PHASE_TRACKER -- requirements
Module: mc_clk_phase_tracker

Interface
REQ-001 Parameter SYNC_STAGES, 2, number of MC_CLK synchroniser flops; legal range 2..4.
REQ-002 Parameter PHASE_W, 6, width of PHASE, PERIOD and HIGH_TIME.
REQ-003 Parameter NUM_STROBES, 2, number of phase-match strobe outputs.
REQ-004 Parameter STROBE_PHASES, {6'd3,6'd17}, packed NUM_STROBES*PHASE_W list; slice i is the match value for strobe i.
REQ-005 Parameter LOCK_COUNT, 4, consecutive in-tolerance periods required for lock.
REQ-006 Parameter LOCK_TOL, 1, maximum allowed period difference, in SYS_CLK cycles.
REQ-007 SYS_CLK  in  1  sole clock; every flop is clocked on its rising edge.
REQ-008 SYS_RST  in  1  reset, synchronous and active-high.
REQ-009 MC_CLK  in  1  asynchronous Amiga 7 MHz clock.
REQ-010 MC_LEVEL  out  1  synchronised MC_CLK level.
REQ-011 MC_RISE / MC_FALL  out  1 each  one-cycle strobes on synchronised rising and falling edges.
REQ-012 PHASE  out  PHASE_W  SYS_CLK cycles since the last MC_RISE.
REQ-013 PERIOD / HIGH_TIME  out  PHASE_W each  last measured rise-to-rise and rise-to-fall times.
REQ-014 PHASE_STB  out  NUM_STROBES  bit i pulses while PHASE equals slice i of STROBE_PHASES.
REQ-015 MC_CLK_STOPPED  out  1  MC_CLK is considered absent.
REQ-016 LOCKED  out  1  MC_CLK period is stable.

Function
REQ-017 MC_CLK shall pass through SYNC_STAGES flops, then one history flop; rise = sync_last & ~hist, fall = ~sync_last & hist.
REQ-018 MC_RISE and MC_FALL shall be registered, so latency from the MC_CLK edge to the strobe is SYNC_STAGES+1 cycles.
REQ-019 PHASE shall load 0 in the same cycle MC_RISE is high, and otherwise increment by 1.
REQ-020 PHASE shall saturate at 2^PHASE_W-1 and never wrap.
REQ-021 MC_CLK_STOPPED shall be 1 whenever PHASE is saturated, and shall clear in the cycle MC_RISE is high.
REQ-022 Internal flag period_valid shall be set by each MC_RISE and cleared by reset or by MC_CLK_STOPPED.
REQ-023 On a rise with period_valid=1, PERIOD shall load min(PHASE+1, 2^PHASE_W-1), registered alongside MC_RISE.
REQ-024 On a rise with period_valid=0, PERIOD shall hold its value.
REQ-025 On a fall with period_valid=1, HIGH_TIME shall load min(PHASE+1, 2^PHASE_W-1).
REQ-026 On a fall with period_valid=0, HIGH_TIME shall hold its value.
REQ-027 PHASE_STB[i] shall be a registered compare of the next PHASE value, so it is high in the same cycle PHASE equals slice i.
REQ-028 PHASE_STB shall be all zero while MC_CLK_STOPPED=1.
REQ-029 A rise coincident with saturation shall give PHASE=0, MC_CLK_STOPPED=0, PERIOD unchanged and period_valid=1.

Reset
REQ-030 While SYS_RST=1, all synchroniser and history flops shall load 0.
REQ-031 While SYS_RST=1, PHASE, PERIOD, HIGH_TIME, PHASE_STB, MC_RISE, MC_FALL, MC_LEVEL, MC_CLK_STOPPED, LOCKED, period_valid and the lock counter shall load 0.
REQ-032 If MC_CLK is high at reset release, a rise shall be reported SYNC_STAGES+1 cycles later, with no PERIOD update.
REQ-033 Reset asserted mid-measurement shall discard the partial measurement; no output shall update from it.

Configuration
REQ-034 Macro MC_CLK_LOCK_DETECT_EN defined: on each valid rise, a counter (saturating at LOCK_COUNT) shall increment if |new PERIOD - old PERIOD| <= LOCK_TOL.
REQ-035 With the macro defined, an out-of-tolerance rise shall reset the counter to 0.
REQ-036 With the macro defined, MC_CLK_STOPPED=1 shall reset the counter to 0.
REQ-037 With the macro defined, LOCKED shall be 1 exactly while the counter equals LOCK_COUNT, and the first valid period after reset or stop shall not be compared.
REQ-038 Macro undefined: LOCKED shall be tied to 0 and no lock logic shall be synthesised.

Structure
REQ-039 Package pistorm16_pkg shall hold the SYNC_STAGES default, the PHASE_W default and a saturating-increment function.
REQ-040 The synchroniser chain shall be sub-module pi_bit_sync (parameter STAGES, async_reg attribute), reusable for other Pi/Amiga crossings.

Verification
REQ-041 MC_CLK period 28 SYS_CLK cycles, 14 high, started after reset -> from the second rise: PERIOD=28, HIGH_TIME=14; first PERIOD update only on the second rise.
REQ-042 Same stimulus -> PHASE_STB[0] high when PHASE=3 and PHASE_STB[1] high when PHASE=17, once per period each.
REQ-043 MC_CLK held low for 70 cycles -> PHASE stops at 63 and MC_CLK_STOPPED=1; the next rise gives PHASE=0, STOPPED=0, PERIOD unchanged.
REQ-044 Macro defined, periods 28,28,29,28,28,28,28 -> LOCKED=1 after the fifth valid period; one period of 31 -> LOCKED=0 at that rise.
REQ-045 SYS_RST pulsed mid-high-phase with MC_CLK=1 -> all outputs 0 during reset; MC_RISE appears 3 cycles after release; PERIOD=0 until the next rise.
REQ-046 Macro undefined, REQ-044 stimulus -> LOCKED constant 0; PERIOD and HIGH_TIME identical to the macro-defined run.

Source files
------------

// File: rtl/pistorm16_pkg.sv
// Shared defaults and helpers for the PiStorm16 Pi/Amiga clock-domain logic.
package pistorm16_pkg;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned PHASE_W_DEFAULT     = 6;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/mc_clk_phase_tracker_if.sv
// Bundle of the Amiga MC_CLK input and the phase-tracker timing outputs.
interface mc_clk_phase_tracker_if
    import pistorm16_pkg::*;
#(
    parameter int unsigned PHASE_W     = PHASE_W_DEFAULT,
    parameter int unsigned NUM_STROBES = 2
);

    logic                   MC_CLK;
    logic                   MC_LEVEL;
    logic                   MC_RISE;
    logic                   MC_FALL;
    logic [PHASE_W-1:0]     PHASE;
    logic [PHASE_W-1:0]     PERIOD;
    logic [PHASE_W-1:0]     HIGH_TIME;
    logic [NUM_STROBES-1:0] PHASE_STB;
    logic                   MC_CLK_STOPPED;
    logic                   LOCKED;

    modport master (
        input  MC_CLK,
        output MC_LEVEL, MC_RISE, MC_FALL, PHASE, PERIOD, HIGH_TIME,
               PHASE_STB, MC_CLK_STOPPED, LOCKED
    );

    modport slave (
        output MC_CLK,
        input  MC_LEVEL, MC_RISE, MC_FALL, PHASE, PERIOD, HIGH_TIME,
               PHASE_STB, MC_CLK_STOPPED, LOCKED
    );

endinterface

// File: rtl/pi_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit; reused for Pi/Amiga crossings.
module pi_bit_sync
    import pistorm16_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEFAULT
)(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* async_reg = "true" *) logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/mc_clk_phase_tracker.sv
// Tracks phase, period and high time of the asynchronous Amiga MC_CLK in the SYS_CLK domain.
// Optional period-lock detector enabled by defining MC_CLK_LOCK_DETECT_EN.
module mc_clk_phase_tracker
    import pistorm16_pkg::*;
#(
    parameter int unsigned                    SYNC_STAGES   = SYNC_STAGES_DEFAULT,
    parameter int unsigned                    PHASE_W       = PHASE_W_DEFAULT,
    parameter int unsigned                    NUM_STROBES   = 2,
    parameter logic [NUM_STROBES*PHASE_W-1:0] STROBE_PHASES = {6'd3, 6'd17},
    parameter int unsigned                    LOCK_COUNT    = 4,
    parameter int unsigned                    LOCK_TOL      = 1
)(
    input logic                    SYS_CLK,
    input logic                    SYS_RST,
    mc_clk_phase_tracker_if.master bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || LOCK_COUNT < 1 || LOCK_TOL >= (32'd1 << PHASE_W)) begin : g_param_check
        $error("mc_clk_phase_tracker: illegal parameter value");
    end

    localparam logic [PHASE_W-1:0] PHASE_MAX = '1;

    logic                   sync_last;
    logic                   hist;
    logic                   rise;
    logic                   fall;
    logic [PHASE_W-1:0]     meas;
    logic [PHASE_W-1:0]     phase_next;
    logic                   stopped_next;
    logic [NUM_STROBES-1:0] stb_next;

    logic                   mc_rise;
    logic                   mc_fall;
    logic                   mc_level;
    logic [PHASE_W-1:0]     phase;
    logic [PHASE_W-1:0]     period;
    logic [PHASE_W-1:0]     high_time;
    logic [NUM_STROBES-1:0] phase_stb;
    logic                   stopped;
    logic                   period_valid;

    pi_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (SYS_CLK),
        .rst (SYS_RST),
        .d   (bus.MC_CLK),
        .q   (sync_last)
    );

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) hist <= 1'b0;
        else         hist <= sync_last;
    end

    assign rise = sync_last & ~hist;
    assign fall = ~sync_last & hist;

    // Strobe slices are listed first-to-last in the parameter, so strobe 0 is the leftmost field.
    always_comb begin
        meas         = PHASE_W'(sat_inc(32'(phase), 32'(PHASE_MAX)));
        phase_next   = rise ? '0 : meas;
        stopped_next = (phase_next == PHASE_MAX);
        stb_next     = '0;
        for (int unsigned i = 0; i < NUM_STROBES; i++) begin
            stb_next[i] = !stopped_next &&
                          (phase_next == STROBE_PHASES[(NUM_STROBES-1-i)*PHASE_W +: PHASE_W]);
        end
    end

    // period_valid drops in the same edge STOPPED rises, so a rise out of saturation never loads PERIOD.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            mc_rise      <= 1'b0;
            mc_fall      <= 1'b0;
            mc_level     <= 1'b0;
            phase        <= '0;
            period       <= '0;
            high_time    <= '0;
            phase_stb    <= '0;
            stopped      <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            mc_rise   <= rise;
            mc_fall   <= fall;
            mc_level  <= sync_last;
            phase     <= phase_next;
            stopped   <= stopped_next;
            phase_stb <= stb_next;
            if (rise)              period_valid <= 1'b1;
            else if (stopped_next) period_valid <= 1'b0;
            if (rise && period_valid) period    <= meas;
            if (fall && period_valid) high_time <= meas;
        end
    end

    assign bus.MC_RISE        = mc_rise;
    assign bus.MC_FALL        = mc_fall;
    assign bus.MC_LEVEL       = mc_level;
    assign bus.PHASE          = phase;
    assign bus.PERIOD         = period;
    assign bus.HIGH_TIME      = high_time;
    assign bus.PHASE_STB      = phase_stb;
    assign bus.MC_CLK_STOPPED = stopped;

`ifdef MC_CLK_LOCK_DETECT_EN
    localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);

    logic [CNT_W-1:0]   lock_cnt;
    logic               have_ref;
    logic [PHASE_W-1:0] delta;
    logic               in_tol;

    always_comb begin
        delta  = (meas >= period) ? meas - period : period - meas;
        in_tol = (32'(delta) <= LOCK_TOL);
    end

    // The first valid period after reset or a stop only establishes the reference.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST || stopped_next) begin
            lock_cnt <= '0;
            have_ref <= 1'b0;
        end else if (rise && period_valid) begin
            have_ref <= 1'b1;
            if (have_ref) begin
                if (!in_tol)                            lock_cnt <= '0;
                else if (lock_cnt != CNT_W'(LOCK_COUNT)) lock_cnt <= lock_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.LOCKED = (lock_cnt == CNT_W'(LOCK_COUNT));
`else
    assign bus.LOCKED = 1'b0;
`endif

endmodule
